// File: rtl/fifo_sync_fwft_if.sv
// Handshake and status bundle for fifo_sync_fwft.
// The master modport drives writes and pops; the slave modport is the FIFO itself.
interface fifo_sync_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 9
);
    logic                  wr_dv;
    logic [DATA_WIDTH-1:0] wr_DATA;
    logic                  wr_full;
    logic                  wr_almost_full;
    logic                  wr_overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_DATA;
    logic                  rd_valid;
    logic                  rd_empty;
    logic                  rd_almost_empty;
    logic                  rd_underflow;
    logic [ADDR_SIZE:0]    level;

    modport master (
        output wr_dv, wr_DATA, rd_en,
        input  wr_full, wr_almost_full, wr_overflow,
        input  rd_DATA, rd_valid, rd_empty, rd_almost_empty, rd_underflow, level
    );

    modport slave (
        input  wr_dv, wr_DATA, rd_en,
        output wr_full, wr_almost_full, wr_overflow,
        output rd_DATA, rd_valid, rd_empty, rd_almost_empty, rd_underflow, level
    );
endinterface

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with BRAM-style synchronous-read storage, optional
// first-word-fall-through prefetch, occupancy level, sticky error flags and flush.
module fifo_sync_fwft #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_SIZE        = 9,
    parameter int FWFT_MODE        = 1,
    parameter int ALMOST_FULL_VAL  = (2**ADDR_SIZE) - 16,
    parameter int ALMOST_EMPTY_VAL = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            clr_err,
    fifo_sync_fwft_if.slave bus
);
    localparam int                 DEPTH   = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_L    = (ADDR_SIZE+1)'(ALMOST_FULL_VAL);
    localparam logic [ADDR_SIZE:0] AE_L    = (ADDR_SIZE+1)'(ALMOST_EMPTY_VAL);
    localparam logic [ADDR_SIZE:0] LVL_ONE = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE:0] LVL_ZERO = (ADDR_SIZE+1)'(0);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ZERO = ADDR_SIZE'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr_r;
    logic [ADDR_SIZE-1:0]  rd_ptr_r;
    logic [ADDR_SIZE:0]    level_r;
    logic [DATA_WIDTH-1:0] ram_q_r;
    logic                  ram_vld_r;
    logic                  out_vld_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_pulse_r;
    logic                  ovf_r;
    logic                  udf_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;
    logic                  move_s;
    logic                  fetch_s;
    logic [ADDR_SIZE:0]    mem_cnt_s;
    logic [ADDR_SIZE:0]    level_nxt_s;
    logic                  ram_vld_nxt_s;
    logic                  out_vld_nxt_s;

    // Acceptance, prefetch pipeline control and next-level computation.
    // In FWFT mode words flow mem -> ram_q_r -> rd_data_r; mem_cnt_s counts
    // words still in the array, i.e. not yet fetched into the pipeline.
    always_comb begin
        full_s        = (level_r == DEPTH_L);
        mem_cnt_s     = level_r - (ADDR_SIZE+1)'(ram_vld_r) - (ADDR_SIZE+1)'(out_vld_r);
        if (FWFT_MODE != 0) begin
            empty_s = !out_vld_r;
        end else begin
            empty_s = (level_r == LVL_ZERO);
        end
        wr_acc_s  = bus.wr_dv && !full_s && !flush;
        rd_acc_s  = bus.rd_en && !empty_s && !flush;
        ovf_set_s = bus.wr_dv && full_s && !flush;
        udf_set_s = bus.rd_en && empty_s && !flush;
        if (FWFT_MODE != 0) begin
            move_s        = ram_vld_r && (!out_vld_r || rd_acc_s) && !flush;
            fetch_s       = (mem_cnt_s != LVL_ZERO) && (!ram_vld_r || move_s) && !flush;
            ram_vld_nxt_s = fetch_s ? 1'b1 : (move_s ? 1'b0 : ram_vld_r);
            out_vld_nxt_s = move_s ? 1'b1 : (rd_acc_s ? 1'b0 : out_vld_r);
        end else begin
            move_s        = 1'b0;
            fetch_s       = rd_acc_s;
            ram_vld_nxt_s = 1'b0;
            out_vld_nxt_s = 1'b0;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.wr_DATA;
        end
    end

    // Synchronous read register of the array, feeding the FWFT output stage.
    always_ff @(posedge clk) begin
        if (fetch_s) begin
            ram_q_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers, level and pipeline valid bits; flush resets them all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            ram_vld_r  <= 1'b0;
            out_vld_r  <= 1'b0;
            rd_pulse_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            ram_vld_r  <= 1'b0;
            out_vld_r  <= 1'b0;
            rd_pulse_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (fetch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_nxt_s;
            ram_vld_r  <= ram_vld_nxt_s;
            out_vld_r  <= out_vld_nxt_s;
            rd_pulse_r <= (FWFT_MODE == 0) && rd_acc_s;
        end
    end

    // Output data register: keeps its last word whenever nothing new is loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (FWFT_MODE != 0) begin
            if (move_s) begin
                rd_data_r <= ram_q_r;
            end
        end else begin
            if (rd_acc_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky error flags; a fresh error wins over clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end
            if (udf_set_s) begin
                udf_r <= 1'b1;
            end else if (clr_err) begin
                udf_r <= 1'b0;
            end
        end
    end

    // Status outputs, all decoded directly from registered state.
    always_comb begin
        bus.wr_full         = full_s;
        bus.wr_almost_full  = (level_r >= AF_L);
        bus.wr_overflow     = ovf_r;
        bus.rd_DATA         = rd_data_r;
        bus.rd_empty        = empty_s;
        bus.rd_almost_empty = (level_r <= AE_L);
        bus.rd_underflow    = udf_r;
        bus.level           = level_r;
        if (FWFT_MODE != 0) begin
            bus.rd_valid = out_vld_r;
        end else begin
            bus.rd_valid = rd_pulse_r;
        end
    end
endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
Parametrised single-clock FIFO for sniffer data buffering, e.g. between the USB3300 capture path and the UART/host drain path.
- Depth, width and almost-full/almost-empty thresholds are set by parameter, as integer levels.
- Supports a real First-Word-Fall-Through (FWFT) mode as well as standard read mode.
- Adds an occupancy level output, sticky overflow/underflow error flags and a synchronous flush.
- Memory is an inferred array with a one-cycle synchronous read, so it maps to iCE40 BRAM.

Parameters:
DATA_WIDTH, 8, word width in bits (1..32).
ADDR_SIZE, 9, log2 of depth; DEPTH = 2**ADDR_SIZE words.
FWFT_MODE, 1, 1 = first-word-fall-through, 0 = standard registered read.
ALMOST_FULL_VAL, DEPTH-16, level at or above which wr_almost_full is high (1..DEPTH).
ALMOST_EMPTY_VAL, 16, level at or below which rd_almost_empty is high (0..DEPTH-1).

Ports:
clk  in  1  reference clock, all logic on rising edge.
rst  in  1  master reset, asynchronous, active LOW.
flush  in  1  synchronous clear of contents (active HIGH).
clr_err  in  1  synchronous clear of sticky error flags.
wr_dv  in  1  write data valid.
wr_DATA  in  DATA_WIDTH  write data.
wr_full  out  1  level == DEPTH.
wr_almost_full  out  1  level >= ALMOST_FULL_VAL.
wr_overflow  out  1  sticky: write attempted while full.
rd_en  in  1  read request / pop.
rd_DATA  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_DATA holds a valid word (see Behaviour).
rd_empty  out  1  no word available to read.
rd_almost_empty  out  1  level <= ALMOST_EMPTY_VAL.
rd_underflow  out  1  sticky: read attempted while empty.
level  out  ADDR_SIZE+1  words held in the FIFO, including any FWFT output register.

Behaviour:
- Reset (rst low, async) values:
  - Pointers and level = 0.
  - rd_DATA = 0, rd_valid = 0, rd_empty = 1, rd_almost_empty = 1.
  - wr_full = 0, wr_almost_full = 0.
  - wr_overflow = 0, rd_underflow = 0.
- Write acceptance: a write is accepted when wr_dv && !wr_full. The word is stored at the write pointer, and the pointer increments and wraps modulo DEPTH.
  - A write while wr_full is dropped and sets wr_overflow.
  - A read in the same cycle does not unblock a write when full.
- Read acceptance: a read is accepted when rd_en && !rd_empty.
  - A read while rd_empty is ignored and sets rd_underflow.
  - A write in the same cycle does not satisfy a read when empty.
- level update: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read or on neither.
- wr_full, wr_almost_full and rd_almost_empty are combinational from level.
- Standard mode (FWFT_MODE=0):
  - rd_empty = (level == 0).
  - rd_DATA updates on the edge after the accepted read (latency 1); rd_valid is high for exactly that one cycle.
  - rd_DATA holds its value otherwise.
- FWFT mode (FWFT_MODE=1):
  - The head word is presented on rd_DATA without a request; rd_valid = !rd_empty.
  - rd_en acts as a pop/acknowledge of the presented word.
  - When a write into an empty FIFO is accepted at edge E0, rd_empty falls and rd_DATA is valid after edge E2. level = 1 after E0.
  - rd_empty can therefore be high while level > 0 during this prefetch window.
  - Popping with level >= 2 presents the next word after the same edge, with no bubble. Sustained throughput is 1 word per clock when level >= 3.
  - rd_DATA holds the old value when empty.
- Wrap-around: pointers are ADDR_SIZE bits wide; full and empty are tracked by level only, never by pointer compare.
- flush (synchronous, highest priority after rst):
  - Clears pointers, level and the FWFT prefetch state; rd_empty = 1, rd_valid = 0.
  - Writes and reads in the flush cycle are ignored and raise no error flags.
  - Error flags are retained.
- clr_err clears both sticky flags on the next edge. A new error in the same cycle takes priority, so its flag stays set.
- Asserting rst mid-transfer returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
1. FWFT=1, DATA_WIDTH=8, ADDR_SIZE=4: write 0xA5 once -> level=1 after E0; rd_empty=0 and rd_DATA=0xA5 after E2; pop -> level=0, rd_empty=1.
2. Fill 16 words 0x00..0x0F, then a 17th write -> wr_full=1, level=16, wr_overflow=1; drain reads 0x00..0x0F in order; then read with rd_en=1 when empty -> rd_underflow=1; clr_err -> both flags 0.
3. Wrap: write 10, read 10, write 12, read 12 -> data order is preserved across the pointer wrap; level ends at 0.
4. At level 8, apply wr_dv=1 and rd_en=1 for 20 cycles -> level stays 8 throughout, output sequence is continuous, no bubbles.
5. FWFT=0: write 0x3C, then assert rd_en -> rd_DATA=0x3C with rd_valid high for exactly one cycle, one edge later.
6. ALMOST_FULL_VAL=12, ALMOST_EMPTY_VAL=3: step level 0..16 -> rd_almost_empty high for 0..3 and wr_almost_full high for 12..16. Then flush at level 9 -> level=0, rd_empty=1, error flags unchanged. rst low mid-write -> immediate reset values.
